// File: rtl/jtframe_romarb_pkg.sv
// rtl/jtframe_romarb_pkg.sv - shared types and helpers for the ROM arbiter
// Bank handshake states, slot count ceiling and slot-index width helper.
package jtframe_romarb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_e;

  localparam int MAX_SLOTS = 8;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtframe_romarb_if.sv
// rtl/jtframe_romarb_if.sv - slot-side and bank-side signals of the ROM arbiter
// slave is the arbiter's view; master is the game/bank environment's view.
interface jtframe_romarb_if #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
);
  logic                  inval;
  logic [SLOTS*AW-1:0]   slot_addr;
  logic [SLOTS-1:0]      slot_cs;
  logic [SLOTS-1:0]      slot_ok;
  logic [SLOTS*DW-1:0]   slot_data;
  logic [AW-1:0]         ba_addr;
  logic                  ba_rd;
  logic                  ba_ack;
  logic                  ba_rdy;
  logic [DW-1:0]         sdram_dout;

  modport slave (
    input  inval, slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
    output slot_ok, slot_data, ba_addr, ba_rd
  );

  modport master (
    output inval, slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
    input  slot_ok, slot_data, ba_addr, ba_rd
  );
endinterface

// File: rtl/jtframe_rr_pick.sv
// rtl/jtframe_rr_pick.sv - combinational grant picker for the ROM arbiter
// Round-robin after last_i; JTFRAME_ROMARB_FIXPRIO_EN selects fixed lowest-index priority.
module jtframe_rr_pick
  import jtframe_romarb_pkg::*;
#(
  parameter int SLOTS = 4
) (
  input  logic [SLOTS-1:0]            pend_i,
  input  logic [idx_w(SLOTS)-1:0]     last_i,
  output logic [idx_w(SLOTS)-1:0]     gnt_o,
  output logic                        any_o
);
  localparam int IW = idx_w(SLOTS);

  assign any_o = |pend_i;

`ifdef JTFRAME_ROMARB_FIXPRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (!found && pend_i[k[IW-1:0]]) begin
        found = 1'b1;
        gnt_o = k[IW-1:0];
      end
    end
  end
`else
  // Scan starts just past the last served slot so it gets lowest priority.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    gnt_o = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      idx = (int'(last_i) + k) % SLOTS;
      if (!found && pend_i[idx[IW-1:0]]) begin
        found = 1'b1;
        gnt_o = idx[IW-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/jtframe_romarb.sv
// rtl/jtframe_romarb.sv - shares one SDRAM bank read port among SLOTS cached ROM requesters
// Each slot keeps a one-entry cache; grant policy lives in jtframe_rr_pick.
module jtframe_romarb
  import jtframe_romarb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic             clk_rom,
  input  logic             rst,
  jtframe_romarb_if.slave  bus
);
  localparam int IW = idx_w(SLOTS);

  state_e            state_q, state_d;
  logic              ba_rd_q, ba_rd_d;
  logic [AW-1:0]     ba_addr_q, ba_addr_d;
  logic [AW-1:0]     lat_addr_q, lat_addr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     rr_last_q;
  logic              stale_q, stale_d;
  logic [SLOTS-1:0]  valid_q;
  logic [AW-1:0]     tag_q  [SLOTS];
  logic [DW-1:0]     data_q [SLOTS];

  logic [AW-1:0]     addr_w [SLOTS];
  logic [SLOTS-1:0]  hit, pend;
  logic [IW-1:0]     pick;
  logic              any, done;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_w[i] = bus.slot_addr[i*AW +: AW];
    assign hit[i]    = bus.slot_cs[i] & valid_q[i] & (addr_w[i] == tag_q[i]);
    assign pend[i]   = bus.slot_cs[i] & ~hit[i];
    assign bus.slot_data[i*DW +: DW] = data_q[i];
  end

  assign bus.slot_ok = hit;
  assign bus.ba_rd   = ba_rd_q;
  assign bus.ba_addr = ba_addr_q;

  jtframe_rr_pick #(.SLOTS(SLOTS)) u_pick (
    .pend_i (pend),
    .last_i (rr_last_q),
    .gnt_o  (pick),
    .any_o  (any)
  );

  // ack and rdy together in WAIT_ACK complete without visiting WAIT_RDY.
  assign done = ((state_q == WAIT_ACK) && bus.ba_ack && bus.ba_rdy) ||
                ((state_q == WAIT_RDY) && bus.ba_rdy);

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.ba_ack) state_d = bus.ba_rdy ? IDLE : WAIT_RDY;
      WAIT_RDY: if (bus.ba_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ba_rd_d    = ba_rd_q;
    ba_addr_d  = ba_addr_q;
    lat_addr_d = lat_addr_q;
    gnt_d      = gnt_q;
    if (state_q == IDLE && any) begin
      ba_rd_d    = 1'b1;
      ba_addr_d  = addr_w[pick];
      lat_addr_d = addr_w[pick];
      gnt_d      = pick;
    end else if (state_q == WAIT_ACK && bus.ba_ack) begin
      ba_rd_d = 1'b0;
    end
    // A transaction overlapping an invalidate must not produce a valid entry.
    if (state_d == IDLE)  stale_d = 1'b0;
    else if (bus.inval)   stale_d = 1'b1;
    else                  stale_d = stale_q;
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      ba_rd_q    <= 1'b0;
      ba_addr_q  <= '0;
      lat_addr_q <= '0;
      gnt_q      <= '0;
      rr_last_q  <= IW'(SLOTS-1);
      stale_q    <= 1'b0;
      valid_q    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      ba_rd_q    <= ba_rd_d;
      ba_addr_q  <= ba_addr_d;
      lat_addr_q <= lat_addr_d;
      gnt_q      <= gnt_d;
      stale_q    <= stale_d;
      if (done) begin
        tag_q[gnt_q]   <= lat_addr_q;
        data_q[gnt_q]  <= bus.sdram_dout;
        valid_q[gnt_q] <= ~stale_q;
        rr_last_q      <= gnt_q;
      end
      if (bus.inval) valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_jtframe_romarb.sv
// tb/tb_jtframe_romarb.sv - directed self-checking bench for jtframe_romarb
module tb_jtframe_romarb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic clk_rom = 1'b0;
  logic rst     = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  logic [AW-1:0] seen;
  logic [AW-1:0] exp_rr [4];
  int            rd_cnt;

  jtframe_romarb_if #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) bus ();

  jtframe_romarb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_rom (clk_rom),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_rom = ~clk_rom;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] sdata(input int i);
    return bus.slot_data[i*DW +: DW];
  endfunction

  task automatic bank_serve(input logic [DW-1:0] dout, output logic [AW-1:0] addr_seen);
    int n;
    n = 0;
    while (bus.ba_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("bank_rd_seen", 64'(bus.ba_rd), 1);
    addr_seen = bus.ba_addr;
    bus.ba_ack = 1'b1;
    tick();
    bus.ba_ack = 1'b0;
    tick();
    bus.ba_rdy = 1'b1;
    bus.sdram_dout = dout;
    tick();
    bus.ba_rdy = 1'b0;
    bus.sdram_dout = '0;
  endtask

  initial begin
    bus.inval = 1'b0;
    bus.slot_cs = '0;
    bus.slot_addr = '0;
    bus.ba_ack = 1'b0;
    bus.ba_rdy = 1'b0;
    bus.sdram_dout = '0;
    exp_rr = '{22'h100, 22'h201, 22'h302, 22'h403};

    // single slot: miss, held request, fill, then zero-latency hit
    bus.slot_cs = 4'b0001;
    set_addr(0, 22'h1234);
    #12;
    check("rst_ba_rd", 64'(bus.ba_rd), 0);
    check("rst_ba_addr", 64'(bus.ba_addr), 0);
    check("rst_ok", 64'(bus.slot_ok), 0);
    check("rst_data0", 64'(sdata(0)), 0);
    @(posedge clk_rom);
    #1 rst = 1'b0;
    tick();
    check("t1_rd", 64'(bus.ba_rd), 1);
    check("t1_addr", 64'(bus.ba_addr), 'h1234);
    tick();
    check("t1_rd_hold", 64'(bus.ba_rd), 1);
    bus.ba_ack = 1'b1;
    tick();
    bus.ba_ack = 1'b0;
    check("t1_rd_drop", 64'(bus.ba_rd), 0);
    tick();
    tick();
    check("t1_ok_wait", 64'(bus.slot_ok), 0);
    bus.ba_rdy = 1'b1;
    bus.sdram_dout = 32'hDEADBEEF;
    tick();
    bus.ba_rdy = 1'b0;
    bus.sdram_dout = '0;
    check("t1_ok", 64'(bus.slot_ok), 'b0001);
    check("t1_data0", 64'(sdata(0)), 'hDEADBEEF);
    rd_cnt = 0;
    repeat (4) begin
      tick();
      if (bus.ba_rd) rd_cnt++;
    end
    check("t1_hit_no_rd", 64'(rd_cnt), 0);
    check("t1_hit_ok", 64'(bus.slot_ok), 'b0001);

    // contention: fresh reset so rr_last = 3 and order is 0,1,2,3
    rst = 1'b1;
    bus.slot_cs = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, exp_rr[i]);
    bus.slot_cs = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bank_serve(32'hA0000000 + 32'(k), seen);
      check($sformatf("rr_order%0d", k), 64'(seen), 64'(exp_rr[k]));
      if (k == 0) begin
        check("rr_data0_first", 64'(sdata(0)), 'hA0000000);
        set_addr(0, 22'h500);
      end
    end
    bank_serve(32'hA0000004, seen);
    check("rr_nostarve", 64'(seen), 'h500);
    check("rr_ok_all", 64'(bus.slot_ok), 'hF);
    check("rr_data0", 64'(sdata(0)), 'hA0000004);
    check("rr_data3", 64'(sdata(3)), 'hA0000003);

    // same-cycle ack+rdy: slot 1 completes, slot 2 issued next IDLE
    set_addr(1, 22'h600);
    set_addr(2, 22'h700);
    bus.slot_cs = 4'b0110;
    tick();
    check("sc_addr1", 64'(bus.ba_addr), 'h600);
    bus.ba_ack = 1'b1;
    bus.ba_rdy = 1'b1;
    bus.sdram_dout = 32'hB0000600;
    tick();
    bus.ba_ack = 1'b0;
    bus.ba_rdy = 1'b0;
    bus.sdram_dout = '0;
    check("sc_ok", 64'(bus.slot_ok), 'b0010);
    check("sc_data1", 64'(sdata(1)), 'hB0000600);
    check("sc_idle_rd", 64'(bus.ba_rd), 0);
    tick();
    check("sc_next_rd", 64'(bus.ba_rd), 1);
    check("sc_next_addr", 64'(bus.ba_addr), 'h700);
    bank_serve(32'hB0000700, seen);
    check("sc_ok2", 64'(bus.slot_ok), 'b0110);

    // address change while waiting for rdy
    set_addr(1, 22'h10);
    bus.slot_cs = 4'b0010;
    tick();
    check("ac_addr_old", 64'(bus.ba_addr), 'h10);
    bus.ba_ack = 1'b1;
    tick();
    bus.ba_ack = 1'b0;
    set_addr(1, 22'h20);
    bus.ba_rdy = 1'b1;
    bus.sdram_dout = 32'hC0000010;
    tick();
    bus.ba_rdy = 1'b0;
    bus.sdram_dout = '0;
    check("ac_ok_low", 64'(bus.slot_ok), 0);
    check("ac_data1_old", 64'(sdata(1)), 'hC0000010);
    tick();
    check("ac_reissue_rd", 64'(bus.ba_rd), 1);
    check("ac_reissue_addr", 64'(bus.ba_addr), 'h20);
    bank_serve(32'hC0000020, seen);
    check("ac_ok_new", 64'(bus.slot_ok), 'b0010);

    // invalidate during WAIT_RDY for slot 2
    set_addr(2, 22'h30);
    bus.slot_cs = 4'b0100;
    tick();
    check("iv_addr", 64'(bus.ba_addr), 'h30);
    bus.ba_ack = 1'b1;
    tick();
    bus.ba_ack = 1'b0;
    bus.inval = 1'b1;
    tick();
    bus.inval = 1'b0;
    bus.ba_rdy = 1'b1;
    bus.sdram_dout = 32'hD0000030;
    tick();
    bus.ba_rdy = 1'b0;
    bus.sdram_dout = '0;
    check("iv_data2", 64'(sdata(2)), 'hD0000030);
    check("iv_ok_low", 64'(bus.slot_ok), 0);
    tick();
    check("iv_reissue_rd", 64'(bus.ba_rd), 1);
    check("iv_reissue_addr", 64'(bus.ba_addr), 'h30);
    bank_serve(32'hD0000031, seen);
    check("iv_ok", 64'(bus.slot_ok), 'b0100);
    check("iv_data2_new", 64'(sdata(2)), 'hD0000031);

    // asynchronous reset during WAIT_ACK
    set_addr(3, 22'h40);
    bus.slot_cs = 4'b1100;
    check("ar_pre_ok", 64'(bus.slot_ok), 'b0100);
    tick();
    check("ar_rd", 64'(bus.ba_rd), 1);
    check("ar_addr", 64'(bus.ba_addr), 'h40);
    #2 rst = 1'b1;
    #1;
    check("ar_async_rd", 64'(bus.ba_rd), 0);
    check("ar_async_ok", 64'(bus.slot_ok), 0);
    tick();
    tick();
    rst = 1'b0;
    bank_serve(32'hE0000030, seen);
    check("ar_first", 64'(seen), 'h30);
    bank_serve(32'hE0000040, seen);
    check("ar_second", 64'(seen), 'h40);
    check("ar_ok", 64'(bus.slot_ok), 'b1100);
    check("ar_data3", 64'(sdata(3)), 'hE0000040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
